// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage; passes ALU results through and runs single
//            outstanding word load/store transactions on the data bus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;
  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [1:0]  mem_op;
    logic [31:0] mem_data;
    logic [31:0] rd_data;
  } mem_params_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mem_params_t mem_params,
  input  logic        in_valid,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        fault
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_rst_q;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [4:0]  r_hold_rd_addr;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd_addr;
  logic [31:0] r_wb_rd_data;
  logic        r_fault;

  logic        w_bus_req_nxt;
  logic        w_bus_we_nxt;
  logic [31:0] w_bus_addr_nxt;
  logic [31:0] w_bus_wdata_nxt;
  logic [4:0]  w_hold_rd_addr_nxt;
  logic        w_wb_valid_nxt;
  logic [4:0]  w_wb_rd_addr_nxt;
  logic [31:0] w_wb_rd_data_nxt;
  logic        w_fault_nxt;
  logic        w_stall;
  logic        w_accept;
  logic        w_is_mem_op;

  // Stall must stay low in the cycle after reset, so nothing is accepted then:
  // a memory op taken without stalling would let its successor slip past.
  assign w_accept    = in_valid && !r_rst_q;
  assign w_is_mem_op = (mem_params.mem_op == MEM_OP_LOAD) ||
                       (mem_params.mem_op == MEM_OP_STORE);

  always_comb begin
    w_state_nxt        = r_state;
    w_bus_req_nxt      = r_bus_req;
    w_bus_we_nxt       = r_bus_we;
    w_bus_addr_nxt     = r_bus_addr;
    w_bus_wdata_nxt    = r_bus_wdata;
    w_hold_rd_addr_nxt = r_hold_rd_addr;
    w_wb_valid_nxt     = 1'b0;
    w_wb_rd_addr_nxt   = r_wb_rd_addr;
    w_wb_rd_data_nxt   = r_wb_rd_data;
    w_fault_nxt        = 1'b0;
    w_stall            = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mem_op) begin
            w_stall            = 1'b1;
            w_state_nxt        = ST_WAIT;
            w_bus_req_nxt      = 1'b1;
            w_bus_we_nxt       = (mem_params.mem_op == MEM_OP_STORE);
            w_bus_addr_nxt     = {mem_params.rd_data[31:2], 2'b00};
            w_bus_wdata_nxt    = mem_params.mem_data;
            w_hold_rd_addr_nxt = mem_params.rd_addr;
          end else begin
            w_wb_valid_nxt   = 1'b1;
            w_wb_rd_addr_nxt = mem_params.rd_addr;
            w_wb_rd_data_nxt = mem_params.rd_data;
          end
        end
      end

      ST_WAIT: begin
        if (bus_err) begin
          w_state_nxt   = ST_IDLE;
          w_bus_req_nxt = 1'b0;
          w_fault_nxt   = 1'b1;
        end else if (bus_ack) begin
          w_state_nxt    = ST_IDLE;
          w_bus_req_nxt  = 1'b0;
          w_wb_valid_nxt = 1'b1;
          if (r_bus_we) begin
            w_wb_rd_addr_nxt = 5'd0;
            w_wb_rd_data_nxt = 32'd0;
          end else begin
            w_wb_rd_addr_nxt = r_hold_rd_addr;
            w_wb_rd_data_nxt = bus_rdata;
          end
        end else begin
          w_stall = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_rst_q        <= 1'b1;
      r_bus_req      <= 1'b0;
      r_bus_we       <= 1'b0;
      r_bus_addr     <= 32'd0;
      r_bus_wdata    <= 32'd0;
      r_hold_rd_addr <= 5'd0;
      r_wb_valid     <= 1'b0;
      r_wb_rd_addr   <= 5'd0;
      r_wb_rd_data   <= 32'd0;
      r_fault        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rst_q        <= 1'b0;
      r_bus_req      <= w_bus_req_nxt;
      r_bus_we       <= w_bus_we_nxt;
      r_bus_addr     <= w_bus_addr_nxt;
      r_bus_wdata    <= w_bus_wdata_nxt;
      r_hold_rd_addr <= w_hold_rd_addr_nxt;
      r_wb_valid     <= w_wb_valid_nxt;
      r_wb_rd_addr   <= w_wb_rd_addr_nxt;
      r_wb_rd_data   <= w_wb_rd_data_nxt;
      r_fault        <= w_fault_nxt;
    end
  end

  assign stall      = w_stall && !rst && !r_rst_q;
  assign wb_valid   = r_wb_valid;
  assign wb_rd_addr = r_wb_rd_addr;
  assign wb_rd_data = r_wb_rd_data;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  mem_params_t mem_params;
  logic        in_valid;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        fault;

  int n_tests;
  int n_fail;

  mem_stage u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_params (mem_params),
    .in_valid   (in_valid),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err),
    .bus_rdata  (bus_rdata),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; a new cycle starts here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] mdata, input logic [31:0] rdata);
    in_valid            = v;
    mem_params.mem_op   = op;
    mem_params.rd_addr  = rd;
    mem_params.mem_data = mdata;
    mem_params.rd_data  = rdata;
  endtask

  task automatic bus_resp(input logic ack, input logic err, input logic [31:0] rdata);
    bus_ack   = ack;
    bus_err   = err;
    bus_rdata = rdata;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b1, MEM_OP_LOAD, 5'd1, 32'h0, 32'h100);
    bus_resp(1'b0, 1'b0, 32'h0);

    // Reset with a load presented: stall must stay low.
    tick();
    tick();
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_wb_data", wb_rd_data, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);

    // First cycle after reset: still no stall, load not taken.
    rst = 1'b0;
    #1;
    check_eq("post_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("post_rst_no_req", {31'd0, bus_req}, 32'd0);
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);

    // Ack while idle is ignored.
    bus_resp(1'b1, 1'b0, 32'h5555_5555);
    tick();
    check_eq("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("idle_ack_req", {31'd0, bus_req}, 32'd0);
    bus_resp(1'b0, 1'b0, 32'h0);

    // NONE op pass-through, latency 1.
    drive(1'b1, MEM_OP_NONE, 5'd3, 32'h0, 32'h1234);
    #1;
    check_eq("none_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    check_eq("none_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("none_wb_addr", {27'd0, wb_rd_addr}, 32'd3);
    check_eq("none_wb_data", wb_rd_data, 32'h1234);
    check_eq("none_no_req", {31'd0, bus_req}, 32'd0);
    tick();
    check_eq("idle_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Load, ack at N+3; upstream keeps presenting it while stalled.
    drive(1'b1, MEM_OP_LOAD, 5'd5, 32'h0, 32'h1003);
    #1;
    check_eq("ld_stall_n", {31'd0, stall}, 32'd1);
    tick();
    check_eq("ld_req_n1", {31'd0, bus_req}, 32'd1);
    check_eq("ld_addr", bus_addr, 32'h1000);
    check_eq("ld_we", {31'd0, bus_we}, 32'd0);
    check_eq("ld_stall_n1", {31'd0, stall}, 32'd1);
    tick();
    check_eq("ld_stall_n2", {31'd0, stall}, 32'd1);
    check_eq("ld_addr_n2", bus_addr, 32'h1000);
    check_eq("ld_wb_n2", {31'd0, wb_valid}, 32'd0);
    tick();
    bus_resp(1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    check_eq("ld_stall_n3", {31'd0, stall}, 32'd0);
    check_eq("ld_req_n3", {31'd0, bus_req}, 32'd1);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    check_eq("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("ld_wb_addr", {27'd0, wb_rd_addr}, 32'd5);
    check_eq("ld_wb_data", wb_rd_data, 32'hDEAD_BEEF);
    check_eq("ld_req_done", {31'd0, bus_req}, 32'd0);
    tick();
    check_eq("ld_no_dup_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("ld_no_dup_req", {31'd0, bus_req}, 32'd0);

    // Store, minimum latency.
    drive(1'b1, MEM_OP_STORE, 5'd7, 32'hCAFE_F00D, 32'h2000);
    #1;
    check_eq("st_stall_n", {31'd0, stall}, 32'd1);
    tick();
    check_eq("st_req", {31'd0, bus_req}, 32'd1);
    check_eq("st_we", {31'd0, bus_we}, 32'd1);
    check_eq("st_addr", bus_addr, 32'h2000);
    check_eq("st_wdata", bus_wdata, 32'hCAFE_F00D);
    bus_resp(1'b1, 1'b0, 32'h0);
    #1;
    check_eq("st_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    check_eq("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("st_wb_addr", {27'd0, wb_rd_addr}, 32'd0);
    check_eq("st_wb_data", wb_rd_data, 32'd0);
    check_eq("st_req_done", {31'd0, bus_req}, 32'd0);
    tick();

    // Load with ack and err together: err wins.
    drive(1'b1, MEM_OP_LOAD, 5'd9, 32'h0, 32'h3000);
    tick();
    tick();
    bus_resp(1'b1, 1'b1, 32'h1111_1111);
    #1;
    check_eq("err_stall", {31'd0, stall}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    check_eq("err_fault", {31'd0, fault}, 32'd1);
    check_eq("err_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("err_req", {31'd0, bus_req}, 32'd0);
    tick();
    check_eq("err_fault_pulse", {31'd0, fault}, 32'd0);

    // Reset during WAIT abandons the access; late ack ignored.
    drive(1'b1, MEM_OP_LOAD, 5'd4, 32'h0, 32'h4000);
    tick();
    check_eq("rw_req_n1", {31'd0, bus_req}, 32'd1);
    tick();
    rst = 1'b1;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    #1;
    check_eq("rw_stall_n2", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rw_req_n3", {31'd0, bus_req}, 32'd0);
    check_eq("rw_addr_n3", bus_addr, 32'd0);
    check_eq("rw_stall_n3", {31'd0, stall}, 32'd0);
    tick();
    bus_resp(1'b1, 1'b0, 32'h9999_9999);
    #1;
    check_eq("rw_stall_n4", {31'd0, stall}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    check_eq("rw_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rw_req_n5", {31'd0, bus_req}, 32'd0);
    check_eq("rw_fault", {31'd0, fault}, 32'd0);

    // Back-to-back load then NONE op.
    drive(1'b1, MEM_OP_LOAD, 5'd10, 32'h0, 32'h5000);
    tick();
    bus_resp(1'b1, 1'b0, 32'h1111_2222);
    #1;
    check_eq("bb_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    drive(1'b1, MEM_OP_NONE, 5'd11, 32'h0, 32'h77);
    #1;
    check_eq("bb_ld_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("bb_ld_addr", {27'd0, wb_rd_addr}, 32'd10);
    check_eq("bb_ld_data", wb_rd_data, 32'h1111_2222);
    check_eq("bb_none_stall", {31'd0, stall}, 32'd0);
    check_eq("bb_req_off", {31'd0, bus_req}, 32'd0);
    tick();
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    check_eq("bb_none_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("bb_none_addr", {27'd0, wb_rd_addr}, 32'd11);
    check_eq("bb_none_data", wb_rd_data, 32'h77);
    check_eq("bb_no_new_req", {31'd0, bus_req}, 32'd0);
    tick();
    check_eq("bb_end_valid", {31'd0, wb_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: mem_params  in  mem_params_t  EX/MEM payload (rd_addr, mem_op, mem_data, rd_data = ALU result / effective address).
REQ-004 SHALL have: in_valid  in  1  mem_params holds a live instruction.
REQ-005 SHALL have: stall  out  1  hold EX/MEM and earlier stages; payload not consumed this cycle.
REQ-006 SHALL have: wb_valid  out  1  / wb_rd_addr  out  5 / wb_rd_data  out  32  registered MEM/WB payload.
REQ-007 SHALL have: bus_req  out  1 / bus_we  out  1 / bus_addr  out  32 / bus_wdata  out  32  data-bus request.
REQ-008 SHALL have: bus_ack  in  1 / bus_err  in  1 / bus_rdata  in  32  data-bus response, valid only with bus_req high.
REQ-009 SHALL have: fault  out  1  one-cycle pulse on bus error.

Function
REQ-010 SHALL implement FSM states IDLE and WAIT.
REQ-011 IDLE, in_valid, mem_op == MEM_OP_NONE: SHALL register wb_valid=1, wb_rd_addr=rd_addr, wb_rd_data=rd_data at next edge (latency 1); stall=0.
REQ-012 IDLE, in_valid, mem_op load/store: SHALL assert stall combinationally in that cycle, latch bus_addr={rd_data[31:2],2'b00}, bus_wdata=mem_data, bus_we=(store), destination rd_addr, and enter WAIT with bus_req=1 from next cycle.
REQ-013 IDLE, in_valid=0: SHALL register wb_valid=0, stall=0.
REQ-014 WAIT: bus_req, bus_we, bus_addr, bus_wdata SHALL stay stable until the cycle ack or err is sampled high.
REQ-015 WAIT, bus_ack=0 and bus_err=0: stall=1, wb_valid registered 0.
REQ-016 WAIT, bus_ack=1, bus_err=0: stall=0 that cycle (held instruction retires); next edge bus_req=0, state IDLE, wb_valid=1; load: wb_rd_addr=latched rd_addr, wb_rd_data=bus_rdata; store: wb_rd_addr=0, wb_rd_data=0.
REQ-017 WAIT, bus_err=1 (priority over bus_ack): stall=0; next edge bus_req=0, IDLE, wb_valid=0, fault=1 for one cycle.
REQ-018 Minimum memory latency: accept at cycle N, bus_req at N+1, ack at N+1 -> wb_valid at N+2; each extra wait cycle adds one.
REQ-019 In WAIT, mem_params/in_valid SHALL be ignored; the instruction presented in the ack cycle SHALL NOT be re-accepted.
REQ-020 bus_ack/bus_err in IDLE SHALL be ignored.
REQ-021 wb_rd_addr=0 SHALL never be treated specially here; suppression of r0 writes is the register file's job.
REQ-022 rd_data[1:0] of a memory op SHALL be dropped (word access only); no misalignment fault.

Reset
REQ-023 rst SHALL force, at next edge: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, wb_valid=0, wb_rd_addr=0, wb_rd_data=0, fault=0.
REQ-024 stall SHALL be 0 while rst is high and in the cycle after.
REQ-025 rst in WAIT SHALL abandon the access; a bus_ack arriving after reset SHALL be ignored.

Verification
REQ-026 NONE op, rd_addr=3, rd_data=0x1234 at N -> wb_valid=1, wb_rd_addr=3, wb_rd_data=0x1234 at N+1, stall never high.
REQ-027 Load, rd_data=0x1003, ack at N+3 with rdata=0xDEADBEEF -> bus_addr=0x1000, bus_we=0, stall high N..N+2, low N+3; wb_rd_data=0xDEADBEEF at N+4.
REQ-028 Store, rd_data=0x2000, mem_data=0xCAFEF00D, ack at N+1 -> bus_we=1, bus_wdata=0xCAFEF00D stable until ack; wb_valid=1, wb_rd_addr=0 at N+2.
REQ-029 Load with ack and err both high at N+2 -> fault pulse at N+3, wb_valid=0, bus_req=0 at N+3.
REQ-030 rst asserted N+2 during WAIT, ack at N+4 -> bus_req=0 from N+3, ack ignored, no wb_valid, stall low.
REQ-031 Back-to-back load then NONE op -> NONE op accepted the cycle after load retires, written back in order, no duplicate load.
